// File: rtl/tdc_multi_edge_encoder_if.sv
// ---------------------------------------------------------------------------
// tdc_multi_edge_encoder_if
//
// Groups the delay-line sample side and the encoded result side of the
// multi-edge TDC encoder into one bundle.
//
//   din         TAP_WIDTH  delay-line snapshot, tap 0 is the earliest tap
//   din_valid   1          din / edge_mode are valid this cycle
//   edge_mode   2          0 = low-to-high, 1 = high-to-low, 2/3 = both
//   dout        OUT_WIDTH  highest-index edge position
//   dout_first  OUT_WIDTH  lowest-index edge position
//   edge_cnt    CNT_WIDTH  number of edges found in the snapshot
//   dout_valid  1          result fields are valid this cycle
//   err         1          no edge, or highest edge beyond the usable range
//
// master: the sampling side (drives din, reads results)
// slave : the encoder itself
// ---------------------------------------------------------------------------
interface tdc_multi_edge_encoder_if #(
    parameter int TAP_WIDTH = 768,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 10
);
    logic [TAP_WIDTH-1:0] din;
    logic                 din_valid;
    logic [1:0]           edge_mode;
    logic [OUT_WIDTH-1:0] dout;
    logic [OUT_WIDTH-1:0] dout_first;
    logic [CNT_WIDTH-1:0] edge_cnt;
    logic                 dout_valid;
    logic                 err;

    modport master (
        output din, din_valid, edge_mode,
        input  dout, dout_first, edge_cnt, dout_valid, err
    );

    modport slave (
        input  din, din_valid, edge_mode,
        output dout, dout_first, edge_cnt, dout_valid, err
    );
endinterface

// File: rtl/tdc_multi_edge_encoder.sv
// ---------------------------------------------------------------------------
// tdc_multi_edge_encoder
//
// Bubble-filtered edge encoder for a tapped delay line. Each snapshot is
// searched for 2-tap-wide transitions of the selected polarity; the highest
// and lowest edge positions and the number of edges are reported three
// cycles after the snapshot is taken, one snapshot per clock.
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active low; clears every pipeline stage
//   bus   tdc_multi_edge_encoder_if.slave (din/din_valid/edge_mode in,
//         dout/dout_first/edge_cnt/dout_valid/err out)
//
// Pipeline:
//   S1  edge vector from the raw snapshot, registered with its valid
//   S2  per-segment highest / lowest local index, nonempty flag, popcount
//   S3  pick highest / lowest nonempty segment, sum counts, range check
// ---------------------------------------------------------------------------
module tdc_multi_edge_encoder #(
    parameter int TAP_WIDTH = 768,
    parameter int SEG_WIDTH = 48,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 10,
    parameter int MAX_CODE  = 576
) (
    input  logic                      clk,
    input  logic                      rst,
    tdc_multi_edge_encoder_if.slave   bus
);
    localparam int NUM_SEG = TAP_WIDTH / SEG_WIDTH;
    localparam int LIDX_W  = $clog2(SEG_WIDTH);
    localparam int SCNT_W  = $clog2(SEG_WIDTH + 1);
    localparam logic [OUT_WIDTH-1:0] MAX_CODE_W = OUT_WIDTH'(MAX_CODE);

    // ------------------------------------------------------------------
    // S1: edge detection. A 4-tap window (i-2..i+1) needs two equal taps
    // on each side, so a 1-tap bubble can never qualify. Taps 0, 1 and
    // TAP_WIDTH-1 have no complete window and never carry an edge.
    // ------------------------------------------------------------------
    logic [TAP_WIDTH-1:0] edge_lh;
    logic [TAP_WIDTH-1:0] edge_hl;
    logic [TAP_WIDTH-1:0] edge_next;
    logic [TAP_WIDTH-1:0] edge_vec_reg;
    logic                 s1_valid_reg;

    for (genvar gi = 0; gi < TAP_WIDTH; gi++) begin : g_edge
        if (gi >= 2 && gi <= TAP_WIDTH - 2) begin : g_win
            assign edge_lh[gi] = ~bus.din[gi-2] & ~bus.din[gi-1] &
                                  bus.din[gi]   &  bus.din[gi+1];
            assign edge_hl[gi] =  bus.din[gi-2] &  bus.din[gi-1] &
                                 ~bus.din[gi]   & ~bus.din[gi+1];
        end else begin : g_none
            assign edge_lh[gi] = 1'b0;
            assign edge_hl[gi] = 1'b0;
        end
    end

    always_comb begin
        edge_next = edge_lh | edge_hl;
        case (bus.edge_mode)
            2'd0:    edge_next = edge_lh;
            2'd1:    edge_next = edge_hl;
            default: edge_next = edge_lh | edge_hl;
        endcase
    end

    // ------------------------------------------------------------------
    // S2: first-level priority encoders. Segments own the tap index i, so
    // an edge whose window straddles a boundary is only seen once.
    // ------------------------------------------------------------------
    logic [NUM_SEG-1:0][LIDX_W-1:0] seg_hi_next, seg_hi_reg;
    logic [NUM_SEG-1:0][LIDX_W-1:0] seg_lo_next, seg_lo_reg;
    logic [NUM_SEG-1:0][SCNT_W-1:0] seg_cnt_next, seg_cnt_reg;
    logic [NUM_SEG-1:0]             seg_nz_next, seg_nz_reg;
    logic                           s2_valid_reg;

    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
        logic [SEG_WIDTH-1:0] bits;
        logic [LIDX_W-1:0]    hi_c;
        logic [LIDX_W-1:0]    lo_c;
        logic [SCNT_W-1:0]    cnt_c;

        assign bits = edge_vec_reg[gi*SEG_WIDTH +: SEG_WIDTH];

        always_comb begin
            hi_c  = '0;
            lo_c  = '0;
            cnt_c = '0;
            for (int k = 0; k < SEG_WIDTH; k++) begin
                if (bits[k]) begin
                    hi_c  = LIDX_W'(k);
                    cnt_c = cnt_c + SCNT_W'(1);
                end
            end
            for (int k = SEG_WIDTH - 1; k >= 0; k--) begin
                if (bits[k]) begin
                    lo_c = LIDX_W'(k);
                end
            end
        end

        assign seg_hi_next[gi]  = hi_c;
        assign seg_lo_next[gi]  = lo_c;
        assign seg_cnt_next[gi] = cnt_c;
        assign seg_nz_next[gi]  = |bits;
    end

    // ------------------------------------------------------------------
    // S3: second-level selection and output formatting.
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] hi_pos;
    logic [OUT_WIDTH-1:0] lo_pos;
    logic [CNT_WIDTH-1:0] total_cnt;
    logic                 any_edge;

    always_comb begin
        hi_pos    = '0;
        lo_pos    = '0;
        total_cnt = '0;
        any_edge  = |seg_nz_reg;
        for (int s = 0; s < NUM_SEG; s++) begin
            if (seg_nz_reg[s]) begin
                hi_pos    = OUT_WIDTH'(s * SEG_WIDTH) + OUT_WIDTH'(seg_hi_reg[s]);
                total_cnt = total_cnt + CNT_WIDTH'(seg_cnt_reg[s]);
            end
        end
        for (int s = NUM_SEG - 1; s >= 0; s--) begin
            if (seg_nz_reg[s]) begin
                lo_pos = OUT_WIDTH'(s * SEG_WIDTH) + OUT_WIDTH'(seg_lo_reg[s]);
            end
        end
    end

    logic [OUT_WIDTH-1:0] dout_reg;
    logic [OUT_WIDTH-1:0] dout_first_reg;
    logic [CNT_WIDTH-1:0] edge_cnt_reg;
    logic                 dout_valid_reg;
    logic                 err_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_vec_reg   <= '0;
            s1_valid_reg   <= 1'b0;
            seg_hi_reg     <= '0;
            seg_lo_reg     <= '0;
            seg_cnt_reg    <= '0;
            seg_nz_reg     <= '0;
            s2_valid_reg   <= 1'b0;
            dout_reg       <= '0;
            dout_first_reg <= '0;
            edge_cnt_reg   <= '0;
            dout_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            edge_vec_reg   <= edge_next;
            s1_valid_reg   <= bus.din_valid;
            seg_hi_reg     <= seg_hi_next;
            seg_lo_reg     <= seg_lo_next;
            seg_cnt_reg    <= seg_cnt_next;
            seg_nz_reg     <= seg_nz_next;
            s2_valid_reg   <= s1_valid_reg;
            dout_valid_reg <= s2_valid_reg;
            // Result fields only move with a valid sample; otherwise they hold.
            if (s2_valid_reg) begin
                if (!any_edge) begin
                    dout_reg       <= '0;
                    dout_first_reg <= '0;
                    edge_cnt_reg   <= '0;
                    err_reg        <= 1'b1;
                end else if (hi_pos >= MAX_CODE_W) begin
                    dout_reg       <= '0;
                    dout_first_reg <= lo_pos;
                    edge_cnt_reg   <= total_cnt;
                    err_reg        <= 1'b1;
                end else begin
                    dout_reg       <= hi_pos;
                    dout_first_reg <= lo_pos;
                    edge_cnt_reg   <= total_cnt;
                    err_reg        <= 1'b0;
                end
            end
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.dout_first = dout_first_reg;
    assign bus.edge_cnt   = edge_cnt_reg;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_tdc_multi_edge_encoder.sv
// ---------------------------------------------------------------------------
// tb_tdc_multi_edge_encoder
//
// Directed vectors for the multi-edge TDC encoder. Inputs are driven on the
// falling edge and outputs are read on the falling edge, so a sample taken
// at rising edge N is expected on the falling edge just before edge N+3.
// ---------------------------------------------------------------------------
module tb_tdc_multi_edge_encoder;
    localparam int TW = 768;
    localparam int OW = 16;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tdc_multi_edge_encoder_if #(.TAP_WIDTH(TW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

    tdc_multi_edge_encoder #(
        .TAP_WIDTH(TW), .SEG_WIDTH(48), .OUT_WIDTH(OW), .CNT_WIDTH(CW), .MAX_CODE(576)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string         name;
        logic [TW-1:0] din;
        logic [1:0]    mode;
        logic [OW-1:0] exp_dout;
        logic [OW-1:0] exp_first;
        logic [CW-1:0] exp_cnt;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // zeros below k, ones from k upward
    function automatic logic [TW-1:0] step_up(input int k);
        logic [TW-1:0] r;
        for (int i = 0; i < TW; i++) r[i] = (i >= k);
        return r;
    endfunction

    // ones below k, zeros from k upward
    function automatic logic [TW-1:0] step_dn(input int k);
        logic [TW-1:0] r;
        for (int i = 0; i < TW; i++) r[i] = (i < k);
        return r;
    endfunction

    function automatic logic [TW-1:0] multi();
        logic [TW-1:0] r;
        for (int i = 0; i < TW; i++)
            r[i] = (i >= 100 && i < 200) || (i >= 300);
        return r;
    endfunction

    function automatic logic [TW-1:0] pulse(input int lo, input int hi);
        logic [TW-1:0] r;
        for (int i = 0; i < TW; i++) r[i] = (i >= lo && i <= hi);
        return r;
    endfunction

    task automatic add(input string n, input logic [TW-1:0] d, input logic [1:0] m,
                       input int ed, input int ef, input int ec, input bit ee);
        vec_t v;
        v.name = n; v.din = d; v.mode = m;
        v.exp_dout = OW'(ed); v.exp_first = OW'(ef); v.exp_cnt = CW'(ec); v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk_out(input string n, input int ed, input int ef, input int ec, input bit ee);
        chk({n, ".valid"}, 32'(bus.dout_valid), 32'd1);
        chk({n, ".dout"},  32'(bus.dout),       32'(ed));
        chk({n, ".first"}, 32'(bus.dout_first), 32'(ef));
        chk({n, ".cnt"},   32'(bus.edge_cnt),   32'(ec));
        chk({n, ".err"},   32'(bus.err),        32'(ee));
    endtask

    initial begin
        //            name        din              mode dout first cnt err
        add("lh100",     step_up(100), 2'd0, 100, 100, 1, 1'b0);
        add("lh100_m1",  step_up(100), 2'd1,   0,   0, 0, 1'b1);
        add("multi_m0",  multi(),      2'd0, 300, 100, 2, 1'b0);
        add("multi_m2",  multi(),      2'd2, 300, 100, 3, 1'b0);
        add("multi_m1",  multi(),      2'd1, 200, 200, 1, 1'b0);
        add("multi_m3",  multi(),      2'd3, 300, 100, 3, 1'b0);
        add("lh600",     step_up(600), 2'd0,   0, 600, 1, 1'b1);
        add("lh48",      step_up(48),  2'd0,  48,  48, 1, 1'b0);
        add("lh47",      step_up(47),  2'd0,  47,  47, 1, 1'b0);
        add("lh575",     step_up(575), 2'd0, 575, 575, 1, 1'b0);
        add("lh576",     step_up(576), 2'd0,   0, 576, 1, 1'b1);
        add("bubble50",  pulse(50, 50), 2'd2,  0,   0, 0, 1'b1);
        add("pair50",    pulse(50, 51), 2'd2, 52,  50, 2, 1'b0);
        add("lh2",       step_up(2),   2'd0,   2,   2, 1, 1'b0);
        add("lh1_none",  step_up(1),   2'd0,   0,   0, 0, 1'b1);
        add("lh766",     step_up(766), 2'd0,   0, 766, 1, 1'b1);
        add("lh767_none",step_up(767), 2'd2,   0,   0, 0, 1'b1);
        add("hl300",     step_dn(300), 2'd1, 300, 300, 1, 1'b0);
        add("hl300_m0",  step_dn(300), 2'd0,   0,   0, 0, 1'b1);

        // Reset state, with a valid sample held on the inputs during reset.
        bus.din = step_up(100); bus.din_valid = 1'b1; bus.edge_mode = 2'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.valid", 32'(bus.dout_valid), 32'd0);
        chk("reset.dout",  32'(bus.dout),       32'd0);
        chk("reset.first", 32'(bus.dout_first), 32'd0);
        chk("reset.cnt",   32'(bus.edge_cnt),   32'd0);
        chk("reset.err",   32'(bus.err),        32'd0);
        rst = 1'b1; bus.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle.valid", 32'(bus.dout_valid), 32'd0);

        // Table: one isolated sample each, exact latency and hold checked.
        foreach (vecs[j]) begin
            bus.din = vecs[j].din; bus.edge_mode = vecs[j].mode; bus.din_valid = 1'b1;
            @(negedge clk);
            bus.din_valid = 1'b0; bus.din = '0; bus.edge_mode = 2'd1;
            @(negedge clk);
            chk({vecs[j].name, ".early"}, 32'(bus.dout_valid), 32'd0);
            @(negedge clk);
            chk_out(vecs[j].name, int'(vecs[j].exp_dout), int'(vecs[j].exp_first),
                    int'(vecs[j].exp_cnt), vecs[j].exp_err);
            @(negedge clk);
            chk({vecs[j].name, ".drop"}, 32'(bus.dout_valid), 32'd0);
            chk({vecs[j].name, ".hold"}, 32'(bus.dout), 32'(vecs[j].exp_dout));
        end

        // Back-to-back stream: edges at 10, 20, ..., 100.
        for (int c = 0; c < 14; c++) begin
            if (c >= 3 && c < 13) begin
                chk($sformatf("stream%0d.valid", c - 3), 32'(bus.dout_valid), 32'd1);
                chk($sformatf("stream%0d.dout", c - 3),  32'(bus.dout), 32'(10 * (c - 2)));
            end else begin
                chk($sformatf("stream_gap%0d.valid", c), 32'(bus.dout_valid), 32'd0);
            end
            bus.din       = step_up(10 * (c + 1));
            bus.edge_mode = 2'd0;
            bus.din_valid = (c < 10);
            @(negedge clk);
        end

        // Same stream, reset for one cycle after the 5th sample.
        for (int c = 0; c < 6; c++) begin
            if (c >= 3) begin
                chk($sformatf("rstream%0d.valid", c - 3), 32'(bus.dout_valid), 32'd1);
                chk($sformatf("rstream%0d.dout", c - 3),  32'(bus.dout), 32'(10 * (c - 2)));
            end
            if (c < 5) begin
                bus.din = step_up(10 * (c + 1)); bus.edge_mode = 2'd0; bus.din_valid = 1'b1;
            end else begin
                bus.din_valid = 1'b0; rst = 1'b0;
            end
            @(negedge clk);
        end
        chk("postrst.valid", 32'(bus.dout_valid), 32'd0);
        chk("postrst.dout",  32'(bus.dout),       32'd0);
        chk("postrst.first", 32'(bus.dout_first), 32'd0);
        chk("postrst.cnt",   32'(bus.edge_cnt),   32'd0);
        chk("postrst.err",   32'(bus.err),        32'd0);

        // First sample after release: edge at 200, mode 2.
        rst = 1'b1;
        bus.din = step_up(200); bus.edge_mode = 2'd2; bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        chk("rel.flush1", 32'(bus.dout_valid), 32'd0);
        @(negedge clk);
        chk("rel.flush2", 32'(bus.dout_valid), 32'd0);
        @(negedge clk);
        chk_out("rel", 200, 200, 1, 1'b0);
        @(negedge clk);
        chk("rel.drop", 32'(bus.dout_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
